alu_issue_queue: RTL

Front-end command stage for the 40-bit `alu`. It accepts {opcode, a, b} commands over a valid/ready handshake and screens out illegal opcodes and divide-by-zero. Legal commands are buffered in a small FIFO and issued to `alu` one at a time. The registered ALU result is captured and returned downstream over a second valid/ready handshake, tagged with its opcode.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/alu_issue_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, error-code and issue-FSM encodings for the ALU front end.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package alu_pkg;

  // ALU select codes; NOP makes the ALU hold its registered output
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01011;

  // Rejection reasons reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIVZERO = 2'b10;

  // Issue FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // Only the four arithmetic opcodes may be queued; NOP is not a command
  function automatic logic op_is_legal(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO holding {opcode, a, b} entries, first-word-fall-through head.
// Latency: a pushed entry is visible at the head one clock after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module cmd_fifo #(
  parameter int DW    = 85,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_dat_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              head_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage array: data needs no reset, pointers qualify it
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Screens {op,a,b} commands, queues legal ones, issues each to the ALU and returns the tagged result.
// Latency: 3 clocks from accept to res_valid when idle; one result per 3 clocks when res_ready stays high.
// Backpressure: in_ready drops only when the FIFO is full; a result waits in HOLD until res_ready.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [4:0]               alu_s,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [4:0]               res_op,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int DW = 5 + 2 * WIDTH;

  logic [DW-1:0]    head;
  logic [4:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;
  logic             fifo_full, fifo_empty;
  logic             accept, is_illegal, is_divzero, push, pop;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]       alu_s_q, alu_s_d, cur_op_q, cur_op_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [4:0]       res_op_q, res_op_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;

  // Screening never stalls the handshake; rejected commands are simply dropped
  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  assign is_illegal = !op_is_legal(in_op);
  assign is_divzero = (in_op == OP_DIV) && (in_b == '0);
  assign push       = accept && !is_illegal && !is_divzero;

  assign head_op = head[DW-1 -: 5];
  assign head_a  = head[2*WIDTH-1 -: WIDTH];
  assign head_b  = head[WIDTH-1:0];

  cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i ({in_op, in_a, in_b}),
    .pop_i      (pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (count)
  );

  // Error pulse: registered one cycle after the rejected handshake
  always_comb begin
    err_valid_d = accept && (is_illegal || is_divzero);
    err_code_d  = ERR_NONE;
    if (accept && is_illegal)      err_code_d = ERR_ILLEGAL;
    else if (accept && is_divzero) err_code_d = ERR_DIVZERO;
  end

  // Issue FSM: load ALU port registers on pop, drop to NOP once the ALU has sampled them
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    cur_op_d    = cur_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    case (state_q)
      ST_IDLE: begin
        alu_s_d = OP_NOP;
        if (!fifo_empty) begin
          pop      = 1'b1;
          alu_a_d  = head_a;
          alu_b_d  = head_b;
          alu_s_d  = head_op;
          cur_op_d = head_op;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // ALU registers the operands at the end of this cycle; freeze it afterwards
        alu_s_d = OP_NOP;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        res_data_d  = alu_out;
        res_op_d    = cur_op_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      default: begin
        // HOLD: result stays stable until taken; no bypass from a same-cycle push
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            alu_s_d  = head_op;
            cur_op_d = head_op;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State registers; reset discards in-flight work and parks the ALU on NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= OP_NOP;
      cur_op_q    <= OP_NOP;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      cur_op_q    <= cur_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule
